// File: rtl/bcd_stopwatch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// bcd_stopwatch_ctrl_pkg
// Shared definitions for the stopwatch control block:
//   - sw_state_t : 2-bit FSM state encoding (ST_IDLE/ST_RUN/ST_PAUSE/ST_LAP),
//                  also driven out on the 'state' port of the top level
//   - clogb2     : ceil(log2(n)) width helper for the prescaler and the
//                  optional debounce counters (never returns less than 1)
// ---------------------------------------------------------------------------
package bcd_stopwatch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_LAP   = 2'b11
    } sw_state_t;

    // Bits needed to hold the values 0..n-1; at least one bit so that a
    // degenerate n still yields a legal vector.
    function automatic int clogb2(input int n);
        int w;
        w = 32'sd1;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < n) begin
                w = i + 32'sd1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/bcd_stopwatch_ctrl_key.sv
// ---------------------------------------------------------------------------
// key_press_detect
// Turns one raw active-low board key into a single-cycle press pulse.
//   clk   : system clock
//   aclr  : asynchronous active-low reset (key treated as released)
//   key_n : raw active-low key level
//   press : one-cycle pulse when the (filtered) level falls from 1 to 0
// Build option: BCD_STOPWATCH_DEBOUNCE_EN inserts a debouncer between the
// synchronizer and the edge detector; the filtered level only follows the
// synchronized key after it has been stable for DB_CYCLES cycles.
// ---------------------------------------------------------------------------
module key_press_detect
    import bcd_stopwatch_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic aclr,
    input  logic key_n,
    output logic press
);

    logic sync1_r;
    logic sync2_r;
    logic level_s;
    logic edge_r;

    // Elaboration guard: the debounce window must be at least one cycle.
    if (DB_CYCLES < 1) begin : g_bad_db_cycles
        $error("key_press_detect: DB_CYCLES must be at least 1");
    end

    // Two-flop synchronizer; resets to the released (high) level.
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= key_n;
            sync2_r <= sync1_r;
        end
    end

`ifdef BCD_STOPWATCH_DEBOUNCE_EN
    localparam int              DB_W    = clogb2(DB_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic [DB_W-1:0] db_cnt_r;
    logic            db_level_r;

    // Debouncer: count consecutive cycles the synchronized level disagrees
    // with the accepted level; any agreement restarts the window.
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            db_cnt_r   <= {DB_W{1'b0}};
            db_level_r <= 1'b1;
        end else if (sync2_r == db_level_r) begin
            db_cnt_r   <= {DB_W{1'b0}};
        end else if (db_cnt_r == DB_LAST) begin
            db_cnt_r   <= {DB_W{1'b0}};
            db_level_r <= sync2_r;
        end else begin
            db_cnt_r   <= db_cnt_r + DB_W'(1);
        end
    end

    assign level_s = db_level_r;
`else
    assign level_s = sync2_r;
`endif

    // Previous filtered level for falling-edge detection.
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            edge_r <= 1'b1;
        end else begin
            edge_r <= level_s;
        end
    end

    // Combinational so that the FSM acts on the press at the very next edge.
    assign press = edge_r & ~level_s;

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_stopwatch_ctrl
// Stopwatch sequencer for a cascaded 3-digit BCD counter chain.
//   clk         : system clock (CLOCK_50)
//   aclr        : asynchronous active-low reset
//   key_start   : raw active-low key, start/stop toggle
//   key_lap     : raw active-low key, lap freeze/release
//   key_clr     : raw active-low key, clear
//   max_reached : chain currently reads 999
//   cnt_en      : one-cycle count enable to the units counter (registered)
//   cnt_aclr    : active-low clear to the chain, one-cycle pulse (registered)
//   disp_hold   : HEX display latch freeze, high only in LAP
//   state       : current FSM state code (IDLE 00, RUN 01, PAUSE 10, LAP 11)
//   led_run     : high in RUN or LAP
// Build option: BCD_STOPWATCH_DEBOUNCE_EN enables key debouncing
// (DB_CYCLES stable cycles); by default keys are only synchronized.
// ---------------------------------------------------------------------------
module bcd_stopwatch_ctrl
    import bcd_stopwatch_ctrl_pkg::*;
#(
    parameter int TICK_DIV  = 5000000,
    parameter int DB_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       aclr,
    input  logic       key_start,
    input  logic       key_lap,
    input  logic       key_clr,
    input  logic       max_reached,
    output logic       cnt_en,
    output logic       cnt_aclr,
    output logic       disp_hold,
    output logic [1:0] state,
    output logic       led_run
);

    localparam int                 PRESC_W   = clogb2(TICK_DIV);
    localparam logic [PRESC_W-1:0] TICK_LAST = PRESC_W'(TICK_DIV - 1);

    logic               press_start_s;
    logic               press_lap_s;
    logic               press_clr_s;

    sw_state_t          state_r;
    sw_state_t          state_nx_s;
    logic [PRESC_W-1:0] presc_r;
    logic [PRESC_W-1:0] presc_nx_s;
    logic               cnt_en_r;
    logic               cnt_en_nx_s;
    logic               cnt_aclr_r;
    logic               cnt_aclr_nx_s;
    logic               disp_hold_r;
    logic               led_run_r;
    logic               running_s;
    logic               tick_s;

    key_press_detect #(.DB_CYCLES(DB_CYCLES)) u_key_start (
        .clk   (clk),
        .aclr  (aclr),
        .key_n (key_start),
        .press (press_start_s)
    );

    key_press_detect #(.DB_CYCLES(DB_CYCLES)) u_key_lap (
        .clk   (clk),
        .aclr  (aclr),
        .key_n (key_lap),
        .press (press_lap_s)
    );

    key_press_detect #(.DB_CYCLES(DB_CYCLES)) u_key_clr (
        .clk   (clk),
        .aclr  (aclr),
        .key_n (key_clr),
        .press (press_clr_s)
    );

    assign running_s = (state_r == ST_RUN) || (state_r == ST_LAP);
    assign tick_s    = running_s && (presc_r == TICK_LAST);

    // Next-state, prescaler and output decode. Commands are prioritised
    // clr > start > lap. A start press freezes the prescaler in the cycle it
    // is taken so a coincident tick is deferred rather than lost.
    always_comb begin
        state_nx_s    = state_r;
        presc_nx_s    = presc_r;
        cnt_en_nx_s   = 1'b0;
        cnt_aclr_nx_s = 1'b1;
        if (press_clr_s) begin
            state_nx_s    = ST_IDLE;
            presc_nx_s    = {PRESC_W{1'b0}};
            cnt_aclr_nx_s = 1'b0;
        end else if (press_start_s) begin
            case (state_r)
                ST_IDLE, ST_PAUSE: state_nx_s = ST_RUN;
                ST_RUN, ST_LAP:    state_nx_s = ST_PAUSE;
                default:           state_nx_s = ST_IDLE;
            endcase
        end else if (running_s) begin
            if (tick_s) begin
                presc_nx_s = {PRESC_W{1'b0}};
            end else begin
                presc_nx_s = presc_r + PRESC_W'(1);
            end
            // A tick at 999 would wrap the chain: drop it and pause instead.
            if (tick_s && max_reached) begin
                state_nx_s = ST_PAUSE;
            end else begin
                cnt_en_nx_s = tick_s;
                if (press_lap_s) begin
                    if (state_r == ST_RUN) begin
                        state_nx_s = ST_LAP;
                    end else begin
                        state_nx_s = ST_RUN;
                    end
                end else begin
                    state_nx_s = state_r;
                end
            end
        end else if (state_r == ST_IDLE) begin
            presc_nx_s = {PRESC_W{1'b0}};
        end else begin
            presc_nx_s = presc_r;
        end
    end

    // State, prescaler and registered outputs; Moore outputs are registered
    // from the next state so they line up with 'state'.
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            state_r     <= ST_IDLE;
            presc_r     <= {PRESC_W{1'b0}};
            cnt_en_r    <= 1'b0;
            cnt_aclr_r  <= 1'b0;
            disp_hold_r <= 1'b0;
            led_run_r   <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            presc_r     <= presc_nx_s;
            cnt_en_r    <= cnt_en_nx_s;
            cnt_aclr_r  <= cnt_aclr_nx_s;
            disp_hold_r <= (state_nx_s == ST_LAP);
            led_run_r   <= (state_nx_s == ST_RUN) || (state_nx_s == ST_LAP);
        end
    end

    assign cnt_en    = cnt_en_r;
    assign cnt_aclr  = cnt_aclr_r;
    assign disp_hold = disp_hold_r;
    assign state     = state_r;
    assign led_run   = led_run_r;

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bcd_stopwatch_ctrl
// Self-checking bench for bcd_stopwatch_ctrl with TICK_DIV=4, DB_CYCLES=3.
// A cycle-level reference model tracks the key history, the stopwatch mode
// and the tick counter as integers; every output is compared each cycle.
// ---------------------------------------------------------------------------
module tb_bcd_stopwatch_ctrl;

    localparam int TICK_DIV  = 4;
    localparam int DB_CYCLES = 3;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_LAP   = 3;

    logic       clk = 1'b0;
    logic       aclr = 1'b1;
    logic       key_start = 1'b1;
    logic       key_lap = 1'b1;
    logic       key_clr = 1'b1;
    logic       max_reached = 1'b0;
    logic       cnt_en;
    logic       cnt_aclr;
    logic       disp_hold;
    logic [1:0] state;
    logic       led_run;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int         m_state;
    int         m_presc;
    logic       m_en;
    logic       m_aclr;
    logic [2:0] kh [0:7];   // kh[i] = key sample (bit0 start, bit1 lap, bit2 clr) i+1 edges ago
    logic [2:0] f1;         // filtered key level after the previous edge
    logic [2:0] f2;         // filtered key level two edges ago

    logic [2:0] keyr;
    logic       mxr;

    always #5 clk = ~clk;

    bcd_stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .DB_CYCLES(DB_CYCLES)) dut (
        .clk         (clk),
        .aclr        (aclr),
        .key_start   (key_start),
        .key_lap     (key_lap),
        .key_clr     (key_clr),
        .max_reached (max_reached),
        .cnt_en      (cnt_en),
        .cnt_aclr    (cnt_aclr),
        .disp_hold   (disp_hold),
        .state       (state),
        .led_run     (led_run)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE;
        m_presc = 0;
        m_en    = 1'b0;
        m_aclr  = 1'b0;
        for (int i = 0; i < 8; i++) kh[i] = 3'b111;
        f1 = 3'b111;
        f2 = 3'b111;
    endtask

    // One rising edge of the reference model; keys/mx are the levels present at the edge.
    task automatic model_edge(input logic [2:0] keys, input logic mx);
        logic [2:0] press;
        logic [2:0] f_new;
        logic       run;
        logic       tick;
        press = f2 & ~f1;
`ifdef BCD_STOPWATCH_DEBOUNCE_EN
        // Filtered level follows the synchronized key once DB_CYCLES samples agree.
        f_new = f1;
        for (int b = 0; b < 3; b++) begin
            logic same;
            same = 1'b1;
            for (int i = 2; i <= DB_CYCLES; i++) begin
                if (kh[i][b] != kh[1][b]) same = 1'b0;
            end
            if (same) f_new[b] = kh[1][b];
        end
`else
        // Synchronized level is simply the key delayed by two edges.
        f_new = kh[0];
`endif
        for (int i = 7; i > 0; i--) kh[i] = kh[i-1];
        kh[0] = keys;
        f2 = f1;
        f1 = f_new;

        run  = (m_state == S_RUN) || (m_state == S_LAP);
        tick = run && (m_presc == TICK_DIV - 1);
        m_en   = 1'b0;
        m_aclr = 1'b1;
        if (press[2]) begin
            m_state = S_IDLE;
            m_presc = 0;
            m_aclr  = 1'b0;
        end else if (press[0]) begin
            m_state = run ? S_PAUSE : S_RUN;
        end else if (run) begin
            m_presc = tick ? 0 : m_presc + 1;
            if (tick && mx) begin
                m_state = S_PAUSE;
            end else begin
                m_en = tick;
                if (press[1]) m_state = (m_state == S_RUN) ? S_LAP : S_RUN;
            end
        end else if (m_state == S_IDLE) begin
            m_presc = 0;
        end
    endtask

    task automatic check_outputs();
        chk("state",     32'(state),     32'(m_state));
        chk("cnt_en",    32'(cnt_en),    32'(m_en));
        chk("cnt_aclr",  32'(cnt_aclr),  32'(m_aclr));
        chk("disp_hold", 32'(disp_hold), 32'(m_state == S_LAP));
        chk("led_run",   32'(led_run),   32'((m_state == S_RUN) || (m_state == S_LAP)));
    endtask

    // Called at a falling edge: drive inputs, let one rising edge pass, check at the next falling edge.
    task automatic cycle(input logic [2:0] keys, input logic mx);
        key_start   = keys[0];
        key_lap     = keys[1];
        key_clr     = keys[2];
        max_reached = mx;
        @(posedge clk);
        model_edge(keys, mx);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic hold(input logic [2:0] keys, input int n, input logic mx);
        repeat (n) cycle(keys, mx);
    endtask

    // Assert reset away from the clock edge, check it takes effect at once, hold n cycles, release.
    task automatic reset_seq(input int n);
        aclr        = 1'b0;
        key_start   = 1'b1;
        key_lap     = 1'b1;
        key_clr     = 1'b1;
        max_reached = 1'b0;
        #1;
        model_reset();
        check_outputs();
        repeat (n) begin
            @(negedge clk);
            check_outputs();
        end
        aclr = 1'b1;
    endtask

    initial begin
        // 1: reset, release, idle for 20 cycles
        reset_seq(3);
        hold(3'b111, 20, 1'b0);

        // 2: start held 5 cycles -> single press, RUN, ticks every 4 cycles
        hold(3'b110, 5, 1'b0);
        hold(3'b111, 4, 1'b0);
        chk("plan2_run", 32'(state), 32'(S_RUN));
        hold(3'b111, 12, 1'b0);

        // 3: lap -> LAP with display frozen, lap again -> RUN
        hold(3'b101, 5, 1'b0);
        hold(3'b111, 4, 1'b0);
        chk("plan3_hold", 32'(disp_hold), 32'(1));
        hold(3'b111, 9, 1'b0);
        hold(3'b101, 5, 1'b0);
        hold(3'b111, 7, 1'b0);

        // 4: start -> PAUSE for 20 cycles, start -> RUN resumes the prescaler
        hold(3'b110, 5, 1'b0);
        hold(3'b111, 20, 1'b0);
        chk("plan4_pause", 32'(state), 32'(S_PAUSE));
        hold(3'b110, 5, 1'b0);
        hold(3'b111, 10, 1'b0);

        // 5: start and clr together in RUN -> IDLE with one-cycle clear
        hold(3'b010, 5, 1'b0);
        hold(3'b111, 4, 1'b0);
        chk("plan5_idle", 32'(state), 32'(S_IDLE));

        // 6: saturation at 999 -> PAUSE, no enable
        hold(3'b110, 5, 1'b0);
        hold(3'b111, 3, 1'b0);
        hold(3'b111, 8, 1'b1);
        chk("plan6_sat", 32'(state), 32'(S_PAUSE));
        hold(3'b011, 5, 1'b0);
        hold(3'b111, 4, 1'b0);

        // Reset asserted while running
        hold(3'b110, 5, 1'b0);
        hold(3'b111, 6, 1'b0);
        reset_seq(2);
        hold(3'b111, 5, 1'b0);

`ifdef BCD_STOPWATCH_DEBOUNCE_EN
        // Two-cycle glitch on start is rejected by the debouncer
        hold(3'b110, 2, 1'b0);
        hold(3'b111, 10, 1'b0);
        chk("glitch_idle", 32'(state), 32'(S_IDLE));
`endif

        // Randomized key activity and max_reached
        keyr = 3'b111;
        mxr  = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < 3; b++) begin
                if ($urandom_range(0, (b == 2) ? 31 : 7) == 0) keyr[b] = ~keyr[b];
            end
            if ($urandom_range(0, 15) == 0) mxr = ~mxr;
            if ($urandom_range(0, 499) == 0) begin
                reset_seq(2);
                keyr = 3'b111;
            end else begin
                cycle(keyr, mxr);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
